// File: rtl/csi_pkt2vid.sv
// CSI-2 byte-stream depacketiser: decodes FS/FE short packets and RAW8 long packets
// into a registered href/vsync/pixel video stream with frame/line counters and sticky errors.
module csi_pkt2vid #(
    parameter int BITS   = 8,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 960
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic            in_sop,
    input  logic [7:0]      in_data,
    input  logic            err_clr,
    output logic            out_href,
    output logic            out_vsync,
    output logic [BITS-1:0] out_raw,
    output logic [15:0]     frame_cnt,
    output logic [15:0]     line_cnt,
    output logic            err_len,
    output logic            err_abort,
    output logic            err_seq,
    output logic [2:0]      dbg_state
);

    // Byte handshake: a byte is consumed on every rising edge where in_valid=1;
    // in_sop is only meaningful together with in_valid. There is no backpressure.
    typedef enum logic [2:0] {IDLE, HDR1, HDR2, HDR3, PAYLOAD, CRC0, CRC1} state_t;

    localparam logic [5:0]  DT_FS    = 6'h00;
    localparam logic [5:0]  DT_FE    = 6'h01;
    localparam logic [5:0]  DT_RAW8  = 6'h2A;
    localparam logic [15:0] WIDTH_W  = 16'(WIDTH);
    localparam logic [15:0] HEIGHT_W = 16'(HEIGHT);

    state_t            state_q, state_d;
    logic [5:0]        di_q, di_d;
    logic [15:0]       rem_q, rem_d;
    logic              raw_pkt_q, raw_pkt_d;
    logic              href_q, href_d;
    logic              vsync_q, vsync_d;
    logic [BITS-1:0]   raw_q, raw_d;
    logic [15:0]       frame_q, frame_d;
    logic [15:0]       line_q, line_d;
    logic              err_len_q, err_len_d;
    logic              err_abort_q, err_abort_d;
    logic              err_seq_q, err_seq_d;
    logic              len_ev, abort_ev, seq_ev;

    always_comb begin
        state_d   = state_q;
        di_d      = di_q;
        rem_d     = rem_q;
        raw_pkt_d = raw_pkt_q;
        href_d    = 1'b0;
        vsync_d   = vsync_q;
        raw_d     = raw_q;
        frame_d   = frame_q;
        line_d    = line_q;
        len_ev    = 1'b0;
        abort_ev  = 1'b0;
        seq_ev    = 1'b0;

        // A new packet start outside IDLE abandons the current packet and re-syncs on it.
        if (in_valid && in_sop && state_q != IDLE) begin
            abort_ev = 1'b1;
            di_d     = in_data[5:0];
            state_d  = HDR1;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    if (in_sop) begin
                        di_d    = in_data[5:0];
                        state_d = HDR1;
                    end
                end
                HDR1: begin
                    rem_d[7:0] = in_data;
                    state_d    = HDR2;
                end
                HDR2: begin
                    rem_d[15:8] = in_data;
                    state_d     = HDR3;
                end
                HDR3: begin
                    state_d   = IDLE;
                    raw_pkt_d = 1'b0;
                    if (di_q == DT_FS) begin
                        seq_ev  = vsync_q;
                        vsync_d = 1'b1;
                        line_d  = 16'd0;
                    end else if (di_q == DT_FE) begin
                        if (!vsync_q) begin
                            seq_ev = 1'b1;
                        end else begin
                            vsync_d = 1'b0;
                            frame_d = frame_q + 16'd1;
                            len_ev  = (line_q != HEIGHT_W);
                        end
                    end else if (di_q >= 6'h10) begin
                        raw_pkt_d = (di_q == DT_RAW8);
                        state_d   = (rem_q == 16'd0) ? CRC0 : PAYLOAD;
                        if (di_q == DT_RAW8) begin
                            if (line_q != 16'hFFFF) line_d = line_q + 16'd1;
                            len_ev = (rem_q != WIDTH_W);
                            seq_ev = !vsync_q;
                        end
                    end
                end
                PAYLOAD: begin
                    if (raw_pkt_q) begin
                        href_d     = 1'b1;
                        raw_d      = '0;
                        raw_d[7:0] = in_data;
                    end
                    rem_d = rem_q - 16'd1;
                    if (rem_q == 16'd1) state_d = CRC0;
                end
                CRC0:    state_d = CRC1;
                CRC1:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Sticky flags: an event in the same cycle as err_clr leaves the flag set.
        err_len_d   = (err_len_q   & ~err_clr) | len_ev;
        err_abort_d = (err_abort_q & ~err_clr) | abort_ev;
        err_seq_d   = (err_seq_q   & ~err_clr) | seq_ev;
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= IDLE;
            di_q        <= '0;
            rem_q       <= '0;
            raw_pkt_q   <= 1'b0;
            href_q      <= 1'b0;
            vsync_q     <= 1'b0;
            raw_q       <= '0;
            frame_q     <= '0;
            line_q      <= '0;
            err_len_q   <= 1'b0;
            err_abort_q <= 1'b0;
            err_seq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            di_q        <= di_d;
            rem_q       <= rem_d;
            raw_pkt_q   <= raw_pkt_d;
            href_q      <= href_d;
            vsync_q     <= vsync_d;
            raw_q       <= raw_d;
            frame_q     <= frame_d;
            line_q      <= line_d;
            err_len_q   <= err_len_d;
            err_abort_q <= err_abort_d;
            err_seq_q   <= err_seq_d;
        end
    end

    assign out_href  = href_q;
    assign out_vsync = vsync_q;
    assign out_raw   = raw_q;
    assign frame_cnt = frame_q;
    assign line_cnt  = line_q;
    assign err_len   = err_len_q;
    assign err_abort = err_abort_q;
    assign err_seq   = err_seq_q;
    assign dbg_state = state_q;

endmodule
